load_align_wb: RTL and testbench

- Load-return side of the data-memory interface, sitting between the MEM stage and register-file writeback.
- The MEM stage issues chip_select and address to the synchronous data SRAM. One cycle later this block captures the SRAM dout, extracts the addressed byte/halfword/word, sign- or zero-extends it per funct3, and drives the WB-stage write port.
- It also owns the MEM/WB pipeline register for writeback metadata and holds the returned load data across WB stalls.

---
 rtl/load_align_wb_pkg.sv | 38 +++
 rtl/load_align_wb_if.sv | 35 +++
 rtl/load_align_wb_load_extend.sv | 40 ++++
 rtl/load_align_wb.sv | 83 ++++++++
 tb/tb_load_align_wb.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/load_align_wb_pkg.sv
// Shared definitions for the load-return / writeback block: load funct3
// encodings, FSM state codes, captured MEM/WB metadata and the fault check.
package load_align_wb_pkg;

   localparam int LA_XLEN    = 32;
   localparam int LA_RADDR_W = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // WB-stage FSM state codes
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_HELD = 2'd2;

   typedef struct packed {
      logic [2:0]            funct3;
      logic [1:0]            addr_lo;
      logic [LA_RADDR_W-1:0] rd_addr;
      logic [LA_XLEN-1:0]    rd_data;
      logic                  reg_write;
      logic                  fault;
   } wb_reg_t;

   // Misaligned word/halfword access or an encoding that is not a load.
   function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_LB, F3_LBU: load_fault = 1'b0;
         F3_LH, F3_LHU: load_fault = lo[0];
         F3_LW:         load_fault = (lo != 2'b00);
         default:       load_fault = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_align_wb_if.sv
// MEM-stage inputs, SRAM read data and register-file write port of the
// load-return block. slave = the block, master = its surroundings.
interface load_align_wb_if
   import load_align_wb_pkg::*;
#(
   parameter int XLEN    = LA_XLEN,
   parameter int RADDR_W = LA_RADDR_W
);
   logic               wb_stall;
   logic               mem_flush;
   logic               mem_mem_read;
   logic               mem_reg_write;
   logic [2:0]         mem_funct3;
   logic [1:0]         mem_addr_lo;
   logic [RADDR_W-1:0] mem_rd_addr;
   logic [XLEN-1:0]    mem_rd_data;
   logic [XLEN-1:0]    dm_dout;
   logic               wb_reg_write;
   logic [RADDR_W-1:0] wb_rd_addr;
   logic [XLEN-1:0]    wb_rd_data;
   logic               wb_load_fault;
   logic               wb_load_busy;

   modport slave (
      input  wb_stall, mem_flush, mem_mem_read, mem_reg_write, mem_funct3,
             mem_addr_lo, mem_rd_addr, mem_rd_data, dm_dout,
      output wb_reg_write, wb_rd_addr, wb_rd_data, wb_load_fault, wb_load_busy
   );

   modport master (
      output wb_stall, mem_flush, mem_mem_read, mem_reg_write, mem_funct3,
             mem_addr_lo, mem_rd_addr, mem_rd_data, dm_dout,
      input  wb_reg_write, wb_rd_addr, wb_rd_data, wb_load_fault, wb_load_busy
   );
endinterface

// File: rtl/load_align_wb_load_extend.sv
// Byte/halfword/word extraction with sign or zero extension. Purely
// combinational so a load-forwarding path can reuse it.
module load_extend
   import load_align_wb_pkg::*;
#(
   parameter int XLEN = LA_XLEN
) (
   input  logic [XLEN-1:0] i_src,
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   output logic [XLEN-1:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
      ext8 = {{(XLEN-8){sgn & b[7]}}, b};
   endfunction

   function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
      ext16 = {{(XLEN-16){sgn & h[15]}}, h};
   endfunction

   assign w_byte = i_src[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_src[{i_addr_lo[1], 4'b0000} +: 16];

   // Select and extend the addressed lane; non-load encodings pass the word.
   always_comb begin
      o_result = i_src;
      case (i_funct3)
         F3_LB:   o_result = ext8(w_byte, 1'b1);
         F3_LBU:  o_result = ext8(w_byte, 1'b0);
         F3_LH:   o_result = ext16(w_half, 1'b1);
         F3_LHU:  o_result = ext16(w_half, 1'b0);
         default: o_result = i_src;
      endcase
   end

endmodule

// File: rtl/load_align_wb.sv
// Load-return side of the data-memory interface: owns the MEM/WB register,
// aligns/extends SRAM read data and holds it across WB stalls.
module load_align_wb
   import load_align_wb_pkg::*;
#(
   parameter int XLEN    = LA_XLEN,
   parameter int RADDR_W = LA_RADDR_W
) (
   input logic           clk,
   input logic           rst,
   load_align_wb_if.slave bus
);

   wb_reg_t         r_wb_p1;
   wb_reg_t         w_next_wb;
   logic [1:0]      r_state_p1;
   logic            r_first_p1;
   logic [XLEN-1:0] r_hold_p1;
   logic            w_is_load;
   logic            w_fault;
   logic            w_busy;
   logic [XLEN-1:0] w_src;
   logic [XLEN-1:0] w_ext;

   // A flushed instruction is a bubble; only a live load can fault.
   assign w_is_load = bus.mem_mem_read & ~bus.mem_flush;
   assign w_fault   = w_is_load & load_fault(bus.mem_funct3, bus.mem_addr_lo);

   assign w_next_wb.funct3    = bus.mem_funct3;
   assign w_next_wb.addr_lo   = bus.mem_addr_lo;
   assign w_next_wb.rd_addr   = bus.mem_rd_addr;
   assign w_next_wb.rd_data   = bus.mem_rd_data;
   assign w_next_wb.reg_write = bus.mem_reg_write & ~bus.mem_flush & ~w_fault;
   assign w_next_wb.fault     = w_fault;

   // ---- MEM -> WB boundary ----
   // MEM/WB metadata register; a stall freezes it (stall beats flush).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_wb_p1 <= '0;
      else if (!bus.wb_stall) r_wb_p1 <= w_next_wb;
   end

   // Marks the first cycle an instruction sits in WB so a fault pulses once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_first_p1 <= 1'b0;
      else     r_first_p1 <= ~bus.wb_stall;
   end

   // WB load FSM: LOAD reads the live SRAM output, HELD reads the hold copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state_p1 <= ST_IDLE;
      else if (!bus.wb_stall)
         r_state_p1 <= (w_is_load & ~w_fault) ? ST_LOAD : ST_IDLE;
      else if (r_state_p1 == ST_LOAD)
         r_state_p1 <= ST_HELD;
   end

   // SRAM output is only valid in the LOAD cycle, so snapshot it on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_hold_p1 <= '0;
      else if (bus.wb_stall && (r_state_p1 == ST_LOAD))
         r_hold_p1 <= bus.dm_dout;
   end

   assign w_busy = (r_state_p1 == ST_LOAD) | (r_state_p1 == ST_HELD);
   assign w_src  = (r_state_p1 == ST_HELD) ? r_hold_p1 : bus.dm_dout;

   load_extend #(.XLEN(XLEN)) u_extend (
      .i_src     (w_src),
      .i_funct3  (r_wb_p1.funct3),
      .i_addr_lo (r_wb_p1.addr_lo),
      .o_result  (w_ext)
   );

   assign bus.wb_reg_write  = r_wb_p1.reg_write;
   assign bus.wb_rd_addr    = RADDR_W'(r_wb_p1.rd_addr);
   assign bus.wb_rd_data    = w_busy ? w_ext : XLEN'(r_wb_p1.rd_data);
   assign bus.wb_load_fault = r_wb_p1.fault & r_first_p1;
   assign bus.wb_load_busy  = w_busy;

endmodule

// File: tb/tb_load_align_wb.sv
// Directed bench for load_align_wb: a vector table for single loads and
// non-loads, plus hand-written stall, fault-stall and reset sequences.
module tb_load_align_wb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   load_align_wb_if #(.XLEN(32), .RADDR_W(5)) bus ();

   load_align_wb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic        rd_en;
      logic        we;
      logic        flush;
      logic [4:0]  rd;
      logic [31:0] rdat;
      logic [31:0] dout;
      logic [31:0] e_data;
      logic        e_we;
      logic        e_fault;
      logic        e_busy;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [1:0] lo, input logic rd_en,
                        input logic we, input logic flush, input logic [4:0] rd,
                        input logic [31:0] rdat);
      bus.mem_funct3    = f3;
      bus.mem_addr_lo   = lo;
      bus.mem_mem_read  = rd_en;
      bus.mem_reg_write = we;
      bus.mem_flush     = flush;
      bus.mem_rd_addr   = rd;
      bus.mem_rd_data   = rdat;
   endtask

   task automatic bubble();
      drive(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      //        f3      lo     rd we fl rd     rdat          dout          e_data        we f  b
      vt[0]  = '{3'b100, 2'd2, 1, 1, 0, 5'd1,  32'h0,        32'h80FF1234, 32'h000000FF, 1, 0, 1};
      vt[1]  = '{3'b000, 2'd2, 1, 1, 0, 5'd2,  32'h0,        32'h80FF1234, 32'hFFFFFFFF, 1, 0, 1};
      vt[2]  = '{3'b001, 2'd2, 1, 1, 0, 5'd3,  32'h0,        32'h80017FFF, 32'hFFFF8001, 1, 0, 1};
      vt[3]  = '{3'b101, 2'd2, 1, 1, 0, 5'd4,  32'h0,        32'h80017FFF, 32'h00008001, 1, 0, 1};
      vt[4]  = '{3'b010, 2'd0, 1, 1, 0, 5'd5,  32'h0,        32'h80017FFF, 32'h80017FFF, 1, 0, 1};
      vt[5]  = '{3'b010, 2'd1, 1, 1, 0, 5'd6,  32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0, 1, 0};
      vt[6]  = '{3'b000, 2'd0, 0, 1, 0, 5'd7,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1, 0, 0};
      vt[7]  = '{3'b000, 2'd0, 1, 1, 0, 5'd8,  32'h0,        32'h00000080, 32'hFFFFFF80, 1, 0, 1};
      vt[8]  = '{3'b101, 2'd0, 1, 1, 0, 5'd9,  32'h0,        32'h1234ABCD, 32'h0000ABCD, 1, 0, 1};
      vt[9]  = '{3'b011, 2'd0, 1, 1, 0, 5'd10, 32'h0,        32'h5A5A5A5A, 32'h00000000, 0, 1, 0};
      vt[10] = '{3'b001, 2'd1, 1, 1, 0, 5'd11, 32'hAAAA0001, 32'h0,        32'hAAAA0001, 0, 1, 0};
      vt[11] = '{3'b100, 2'd1, 1, 1, 0, 5'd12, 32'h0,        32'h0000A500, 32'h000000A5, 1, 0, 1};
      vt[12] = '{3'b010, 2'd0, 1, 1, 0, 5'd13, 32'h0,        32'h11111111, 32'h11111111, 1, 0, 1};
      vt[13] = '{3'b010, 2'd0, 1, 1, 0, 5'd14, 32'h0,        32'h22222222, 32'h22222222, 1, 0, 1};
      vt[14] = '{3'b010, 2'd0, 1, 1, 1, 5'd15, 32'h0BADF00D, 32'h99999999, 32'h0BADF00D, 0, 0, 0};
      vt[15] = '{3'b000, 2'd0, 0, 1, 0, 5'd0,  32'h00000042, 32'h0,        32'h00000042, 1, 0, 0};
      vt[16] = '{3'b110, 2'd0, 1, 1, 0, 5'd16, 32'h0,        32'h0,        32'h00000000, 0, 1, 0};

      bus.wb_stall = 1'b0;
      bus.dm_dout  = 32'h0;
      bubble();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_data",  bus.wb_rd_data, 32'h0);
      chk("rst_we",    {31'b0, bus.wb_reg_write}, 32'h0);
      chk("rst_addr",  {27'b0, bus.wb_rd_addr}, 32'h0);
      chk("rst_fault", {31'b0, bus.wb_load_fault}, 32'h0);
      chk("rst_busy",  {31'b0, bus.wb_load_busy}, 32'h0);
      rst = 1'b0;

      // Table: back-to-back issue, dm_dout valid in the WB cycle
      @(negedge clk);
      drive(vt[0].f3, vt[0].lo, vt[0].rd_en, vt[0].we, vt[0].flush, vt[0].rd, vt[0].rdat);
      for (int i = 0; i < 17; i++) begin
         @(posedge clk);
         #1;
         bus.dm_dout = vt[i].dout;
         bubble();
         @(negedge clk);
         chk($sformatf("v%0d_data", i),  bus.wb_rd_data, vt[i].e_data);
         chk($sformatf("v%0d_we", i),    {31'b0, bus.wb_reg_write}, {31'b0, vt[i].e_we});
         chk($sformatf("v%0d_rd", i),    {27'b0, bus.wb_rd_addr}, {27'b0, vt[i].rd});
         chk($sformatf("v%0d_fault", i), {31'b0, bus.wb_load_fault}, {31'b0, vt[i].e_fault});
         chk($sformatf("v%0d_busy", i),  {31'b0, bus.wb_load_busy}, {31'b0, vt[i].e_busy});
         if (i < 16)
            drive(vt[i+1].f3, vt[i+1].lo, vt[i+1].rd_en, vt[i+1].we, vt[i+1].flush,
                  vt[i+1].rd, vt[i+1].rdat);
      end

      // lb at addr_lo=3 held across three stalled edges while dm_dout changes
      @(negedge clk);
      drive(3'b000, 2'd3, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0);
      @(posedge clk);
      #1;
      bus.dm_dout  = 32'h7F000000;
      bus.wb_stall = 1'b1;
      bubble();
      @(negedge clk);
      chk("hold_c0_data", bus.wb_rd_data, 32'h0000007F);
      chk("hold_c0_busy", {31'b0, bus.wb_load_busy}, 32'h1);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         bus.dm_dout = 32'hDEADBEEF;
         drive(3'b010, 2'd0, 1'b1, 1'b1, 1'b1, 5'd20, 32'h0);
         @(negedge clk);
         chk($sformatf("hold_c%0d_data", c), bus.wb_rd_data, 32'h0000007F);
         chk($sformatf("hold_c%0d_busy", c), {31'b0, bus.wb_load_busy}, 32'h1);
         chk($sformatf("hold_c%0d_rd", c),   {27'b0, bus.wb_rd_addr}, 32'd9);
         chk($sformatf("hold_c%0d_we", c),   {31'b0, bus.wb_reg_write}, 32'h1);
      end
      bus.wb_stall = 1'b0;
      drive(3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h00000055);
      @(posedge clk);
      #1;
      bubble();
      @(negedge clk);
      chk("after_hold_data", bus.wb_rd_data, 32'h00000055);
      chk("after_hold_rd",   {27'b0, bus.wb_rd_addr}, 32'd7);
      chk("after_hold_busy", {31'b0, bus.wb_load_busy}, 32'h0);

      // Faulting load under stall: fault pulses only in its first WB cycle
      drive(3'b010, 2'd2, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0);
      @(posedge clk);
      #1;
      bubble();
      bus.wb_stall = 1'b1;
      @(negedge clk);
      chk("fstall_fault0", {31'b0, bus.wb_load_fault}, 32'h1);
      chk("fstall_we0",    {31'b0, bus.wb_reg_write}, 32'h0);
      chk("fstall_busy0",  {31'b0, bus.wb_load_busy}, 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fstall_fault1", {31'b0, bus.wb_load_fault}, 32'h0);
      chk("fstall_we1",    {31'b0, bus.wb_reg_write}, 32'h0);
      bus.wb_stall = 1'b0;

      // Reset asserted while a load is HELD
      drive(3'b010, 2'd0, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0);
      @(posedge clk);
      #1;
      bus.dm_dout  = 32'h13572468;
      bus.wb_stall = 1'b1;
      bubble();
      @(posedge clk);
      #1;
      bus.dm_dout = 32'h0;
      @(negedge clk);
      chk("prerst_data", bus.wb_rd_data, 32'h13572468);
      chk("prerst_busy", {31'b0, bus.wb_load_busy}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_data",  bus.wb_rd_data, 32'h0);
      chk("arst_we",    {31'b0, bus.wb_reg_write}, 32'h0);
      chk("arst_addr",  {27'b0, bus.wb_rd_addr}, 32'h0);
      chk("arst_fault", {31'b0, bus.wb_load_fault}, 32'h0);
      chk("arst_busy",  {31'b0, bus.wb_load_busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.wb_stall = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("postrst_we",   {31'b0, bus.wb_reg_write}, 32'h0);
      chk("postrst_busy", {31'b0, bus.wb_load_busy}, 32'h0);
      chk("postrst_data", bus.wb_rd_data, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
